serial_adder_subtractor: RTL and testbench
==========================================

SERIAL_ADDER_SUBTRACTOR -- requirements
Module: serial_adder_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits, legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one operation; sampled only in IDLE.
REQ-005 SHALL have port sel  input  1  mode: 0 = A+B, 1 = A-B (two's complement, B inverted, carry-in 1).
REQ-006 SHALL have port A  input  WIDTH  first operand; captured when start is accepted.
REQ-007 SHALL have port B  input  WIDTH  second operand; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a new result on S/cout.
REQ-010 SHALL have port S  output  WIDTH  registered result of the last completed operation.
REQ-011 SHALL have port cout  output  1  final carry; in subtract mode 1 = no borrow (A >= B unsigned).

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE: IDLE->SHIFT on start=1; SHIFT->DONE after WIDTH SHIFT cycles; DONE->IDLE unconditionally on the next edge.
REQ-013 SHALL, on accepting start, load A, B and sel into internal registers, set the carry register to sel, and clear the bit counter.
REQ-014 SHALL, in each SHIFT cycle, compute one result bit LSB-first: sum = a0 ^ (b0 ^ sel_r) ^ c; update the carry with the majority function; shift the operand registers right; shift the sum bit into the MSB of the internal result register.
REQ-015 SHALL take S and cout from the internal result and carry on the edge that leaves SHIFT; S and cout are held unchanged until the next completion.
REQ-016 SHALL meet this latency: start accepted at edge 0; busy high from edge 0 to edge WIDTH; done high from edge WIDTH to edge WIDTH+1, with S/cout valid from edge WIDTH.
REQ-017 SHALL ignore start while in SHIFT or DONE, with no effect on the operation in progress.
REQ-018 SHALL ignore changes to A, B and sel after capture; they do not affect the operation in progress.
REQ-019 SHALL allow back-to-back operation: start held high re-accepts in IDLE, two cycles after done rises.
REQ-020 SHALL produce S equal to (A ± B) mod 2^WIDTH, with wrap-around and no saturation.

Reset
REQ-021 SHALL force, on rst=1 at any time and without waiting for a clock edge, state=IDLE, busy=0, done=0, S=0, cout=0, counter=0, and ovf=0 when ovf is present.
REQ-022 SHALL abort an operation interrupted by reset mid-SHIFT: no done pulse, S keeps its reset value, and the first start after rst falls is accepted normally.

Configuration
REQ-023 SHALL, when macro SERIAL_ADDSUB_OVF_EN is defined, add output ovf (1 bit): signed overflow = carry into the MSB XOR the final carry, registered and updated together with S, valid from the same edge as S.
REQ-024 SHALL, when SERIAL_ADDSUB_OVF_EN is undefined, have neither the ovf port nor its logic; all other behaviour is identical.

Structure
REQ-025 SHALL take the state encoding constants (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) from shared package serial_addsub_pkg.
REQ-026 SHALL take the counter-width constant/function (clog2 of WIDTH+1) from the same package.
REQ-027 SHALL instantiate the single 1-bit combinational sub-module full_adder (a, b, cin -> s, cout) for the per-cycle bit slice.

Verification
REQ-028 SHALL cover subtract, WIDTH=4, sel=1, A=1101, B=1111 -> S=1110, cout=0, ovf=0.
REQ-029 SHALL cover subtract, sel=1, A=1000, B=0101 -> S=0011, cout=1, ovf=1.
REQ-030 SHALL cover add, sel=0: A=1101, B=1111 -> S=1100, cout=1, ovf=0; A=0100, B=0111 -> S=1011, cout=0, ovf=1.
REQ-031 SHALL cover timing: start pulse at edge 0 -> busy high edges 0..4, done high exactly edges 4..5; start and changed A/B/sel during busy -> result unchanged, no second done.
REQ-032 SHALL cover reset: rst asserted after edge 2 of an operation -> outputs 0 immediately, no done; a new start (A=0011, B=1100, sel=0) -> S=1111, cout=0.
REQ-033 SHALL cover WIDTH=8, sel=0, A=0xFF, B=0x01 -> S=0x00, cout=1, ovf=0, with done at edge 8.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared FSM state encoding and counter sizing for the serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_subtractor_full_adder.sv
// One-bit combinational full adder used as the per-cycle bit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_subtractor.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_subtractor
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sel_r;
    logic             c_r;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_next;

    // Result register is one bit narrower: the final sum bit goes straight into S.
    logic [WIDTH-2:0] res_r;
    logic [WIDTH-1:0] res_ext;

    assign res_ext = {sum_bit, res_r};

    full_adder u_fa (
        .a    (a_r[0]),
        .b    (b_r[0] ^ sel_r),
        .cin  (c_r),
        .s    (sum_bit),
        .cout (carry_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sel_r <= 1'b0;
            c_r   <= 1'b0;
            cnt   <= '0;
            res_r <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        sel_r <= sel;
                        c_r   <= sel;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_r   <= a_r >> 1;
                    b_r   <= b_r >> 1;
                    c_r   <= carry_next;
                    res_r <= res_ext[WIDTH-1:1];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        S     <= res_ext;
                        cout  <= carry_next;
`ifdef SERIAL_ADDSUB_OVF_EN
                        ovf   <= c_r ^ carry_next;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Self-checking bench for serial_adder_subtractor (WIDTH=4 and WIDTH=8 instances).
module tb_serial_adder_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, sel4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, s4;
    logic       start8, sel8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, s8;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          cur_w    = 4;

    logic        busy_o, done_o, cout_o, ovf_o;
    logic [31:0] s_o;

    always #5 clk = ~clk;

    serial_adder_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sel(sel4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .S(s4), .cout(cout4)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    serial_adder_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sel(sel8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .S(s8), .cout(cout8)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

`ifndef SERIAL_ADDSUB_OVF_EN
    assign ovf4 = 1'b0;
    assign ovf8 = 1'b0;
`endif

    always_comb begin
        if (cur_w == 8) begin
            busy_o = busy8; done_o = done8; cout_o = cout8; ovf_o = ovf8;
            s_o    = {24'b0, s8};
        end else begin
            busy_o = busy4; done_o = done4; cout_o = cout4; ovf_o = ovf4;
            s_o    = {28'b0, s4};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: (A +/- B) mod 2^w, carry out of bit w, signed overflow from operand/result signs.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic [32:0] mask, full;
        logic [31:0] r;
        logic        c, v, sa, sb, sr;
        mask = (33'd1 << w) - 33'd1;
        full = ({1'b0, a} & mask) + (s ? (((~{1'b0, b}) & mask) + 33'd1) : ({1'b0, b} & mask));
        r    = full[31:0] & mask[31:0];
        c    = full[w];
        sa   = a[w-1];
        sb   = b[w-1] ^ s;
        sr   = r[w-1];
        v    = (sa == sb) && (sr != sa);
        return {v, c, r};
    endfunction

    task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        if (w == 8) begin
            start8 = st; a8 = a[7:0]; b8 = b[7:0]; sel8 = s;
        end else begin
            start4 = st; a4 = a[3:0]; b4 = b[3:0]; sel4 = s;
        end
    endtask

    task automatic check_result(input int w, input logic [33:0] m);
        check($sformatf("S w%0d", w), s_o, m[31:0]);
        check($sformatf("cout w%0d", w), 32'(cout_o), 32'(m[32]));
`ifdef SERIAL_ADDSUB_OVF_EN
        check($sformatf("ovf w%0d", w), 32'(ovf_o), 32'(m[33]));
`endif
    endtask

    // One operation with full edge-by-edge timing checks; disturb drives start and
    // new operands during SHIFT, which must not affect the result.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit disturb);
        logic [33:0] m;
        m = model(w, a, b, s);
        cur_w = w;
        @(negedge clk);
        drive(w, 1'b1, a, b, s);
        @(posedge clk); #1;
        check("busy edge0", 32'(busy_o), 32'd1);
        check("done edge0", 32'(done_o), 32'd0);
        for (int k = 1; k <= w; k++) begin
            @(negedge clk);
            if (disturb && k < w) drive(w, 1'b1, $urandom, $urandom, 1'($urandom));
            else drive(w, 1'b0, a, b, s);
            @(posedge clk); #1;
            if (k < w) begin
                check($sformatf("busy shift k%0d", k), 32'(busy_o), 32'd1);
                check($sformatf("done shift k%0d", k), 32'(done_o), 32'd0);
            end else begin
                check("busy at done", 32'(busy_o), 32'd0);
                check("done pulse", 32'(done_o), 32'd1);
                check_result(w, m);
            end
        end
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            check("done after pulse", 32'(done_o), 32'd0);
            check("busy after pulse", 32'(busy_o), 32'd0);
            check("S held", s_o, m[31:0]);
        end
    endtask

    initial begin
        logic [33:0] m1, m2;
        rst = 1'b1;
        drive(4, 1'b0, 0, 0, 1'b0);
        drive(8, 1'b0, 0, 0, 1'b0);
        #2;
        check("reset busy4", 32'(busy4), 32'd0);
        check("reset done4", 32'(done4), 32'd0);
        check("reset S4", 32'(s4), 32'd0);
        check("reset cout4", 32'(cout4), 32'd0);
        check("reset ovf4", 32'(ovf4), 32'd0);
        check("reset S8", 32'(s8), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(4, 32'b1101, 32'b1111, 1'b1, 1'b0);
        run_op(4, 32'b1000, 32'b0101, 1'b1, 1'b0);
        run_op(4, 32'b1101, 32'b1111, 1'b0, 1'b1);
        run_op(4, 32'b0100, 32'b0111, 1'b0, 1'b0);

        // Back-to-back: start held high; second accept at edge 6, done at edges 4 and 10.
        cur_w = 4;
        m1 = model(4, 5, 6, 1'b0);
        m2 = model(4, 9, 3, 1'b0);
        @(negedge clk);
        drive(4, 1'b1, 5, 6, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("b2b done k%0d", k), 32'(done_o), 32'((k == 4) || (k == 10)));
            if (k == 4) begin
                check_result(4, m1);
                drive(4, 1'b1, 9, 3, 1'b0);
            end
            if (k == 6) drive(4, 1'b0, 9, 3, 1'b0);
            if (k == 10) check_result(4, m2);
        end

        // Reset mid-SHIFT: outputs clear without a clock edge and no done follows.
        @(negedge clk);
        drive(4, 1'b1, 4'hA, 4'h3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(4, 1'b0, 4'hA, 4'h3, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst busy", 32'(busy4), 32'd0);
        check("rst done", 32'(done4), 32'd0);
        check("rst S", 32'(s4), 32'd0);
        check("rst cout", 32'(cout4), 32'd0);
        check("rst ovf", 32'(ovf4), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("no done after abort", 32'(done4), 32'd0);
            check("S after abort", 32'(s4), 32'd0);
        end
        run_op(4, 32'b0011, 32'b1100, 1'b0, 1'b0);

        run_op(8, 32'hFF, 32'h01, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++)
            run_op(4, $urandom, $urandom, 1'($urandom), 1'($urandom));
        for (int i = 0; i < 12; i++)
            run_op(8, $urandom, $urandom, 1'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
